output_stream_collector: RTL and testbench

Receiver for the engine's packed activation output stream. Accepts 64-bit output words, which the engine pushes with valid only and never stalls on ready. Buffers them in a FIFO and re-emits them as 32-bit HWPE-stream beats with full valid/ready handshake toward the streamer. Tracks the per-layer word count and reports completion and loss.

---
 rtl/output_stream_collector_if.sv | 26 ++
 rtl/output_stream_collector.sv | 171 +++++++++++++++++
 tb/tb_output_stream_collector.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/output_stream_collector_if.sv
// rtl/output_stream_collector_if.sv - stream bundle for output_stream_collector
//
// Input side : in_valid, in_data[63:0] (engine pushes, never stalls),
//              in_ready (informational only).
// Output side: out_data[31:0], out_valid, out_strb[3:0], out_ready
//              (full valid/ready handshake toward the streamer).
// master = engine/streamer side, slave = collector side.
interface output_stream_collector_if;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic [3:0]  out_strb;
  logic        out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_data, out_valid, out_strb
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_data, out_valid, out_strb
  );
endinterface

// File: rtl/output_stream_collector.sv
// rtl/output_stream_collector.sv - 64-bit word FIFO to 32-bit beat collector
//
// Buffers engine output words in a DEPTH-entry FIFO and re-emits each word as
// two 32-bit beats (low half first). Counts words per layer and reports
// completion (done_o) and dropped words (error_o).
//
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   clear_i             synchronous clear, same effect as reset
//   start_i             arm one layer (sampled in IDLE only)
//   expected_words_i    words expected for the layer, sampled with start_i
//   strm (slave)        in_valid/in_data/in_ready and
//                       out_data/out_valid/out_strb/out_ready
//   done_o              one-cycle pulse: layer complete and drained
//   busy_o              high in RUN and DRAIN
//   error_o             sticky: a word was dropped
//   accepted_o          words accepted this layer (saturating)
//
// Build option: OUTPUT_COLLECTOR_BYTE_SWAP_EN byte-reverses every beat.
module output_stream_collector #(
  parameter int DEPTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  input  logic                      start_i,
  input  logic [CNT_WIDTH-1:0]      expected_words_i,
  output_stream_collector_if.slave  strm,
  output logic                      done_o,
  output logic                      busy_o,
  output logic                      error_o,
  output logic [CNT_WIDTH-1:0]      accepted_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t               state;
  logic [63:0]          mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          occ;
  logic [AW:0]          occ_next;
  logic                 beat_sel;
  logic [CNT_WIDTH-1:0] expected;
  logic [CNT_WIDTH-1:0] acc_inc;

  logic        not_empty;
  logic        full;
  logic        hs;
  logic        pop;
  logic        push;
  logic        drop;
  logic [63:0] head;
  logic [31:0] beat;

  assign not_empty = (occ != '0);
  assign full      = (occ == FULL_CNT);
  assign hs        = not_empty & strm.out_ready;
  // The head leaves the FIFO only once its upper half has been taken.
  assign pop       = hs & beat_sel;
  // A full FIFO still takes a word when the head is popped on this edge.
  assign push      = strm.in_valid & (state == RUN) & (~full | pop);
  assign drop      = strm.in_valid & ~push;

  assign acc_inc   = (accepted_o == '1) ? accepted_o : accepted_o + 1'b1;

  always_comb begin
    occ_next = occ;
    case ({push, pop})
      2'b10:   occ_next = occ + 1'b1;
      2'b01:   occ_next = occ - 1'b1;
      default: occ_next = occ;
    endcase
  end

  assign head = mem[rd_ptr];
  assign beat = beat_sel ? head[63:32] : head[31:0];

  // Data is forced to zero when nothing is buffered so the output is
  // well-defined out of reset without clearing the storage array.
  always_comb begin
    strm.out_data = '0;
    if (not_empty) begin
`ifdef OUTPUT_COLLECTOR_BYTE_SWAP_EN
      strm.out_data = {beat[7:0], beat[15:8], beat[23:16], beat[31:24]};
`else
      strm.out_data = beat;
`endif
    end
  end

  assign strm.out_valid = not_empty;
  assign strm.out_strb  = 4'hF;
  assign strm.in_ready  = ~full;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= strm.in_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      beat_sel   <= 1'b0;
      expected   <= '0;
      accepted_o <= '0;
      done_o     <= 1'b0;
      busy_o     <= 1'b0;
      error_o    <= 1'b0;
    end else if (clear_i) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      beat_sel   <= 1'b0;
      expected   <= '0;
      accepted_o <= '0;
      done_o     <= 1'b0;
      busy_o     <= 1'b0;
      error_o    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      occ      <= occ_next;
      beat_sel <= beat_sel ^ hs;
      done_o   <= 1'b0;
      error_o  <= error_o | drop;

      case (state)
        IDLE: begin
          if (start_i) begin
            expected   <= expected_words_i;
            accepted_o <= '0;
            // start clears the sticky flag; a stray word in this cycle still counts
            error_o    <= drop;
            busy_o     <= 1'b1;
            state      <= (expected_words_i == '0) ? DRAIN : RUN;
          end
        end
        RUN: begin
          if (push) begin
            accepted_o <= acc_inc;
            if (acc_inc >= expected) state <= DRAIN;
          end
        end
        DRAIN: begin
          // Looking at the next occupancy makes done_o land the cycle after
          // the final beat-1 handshake.
          if (occ_next == '0) begin
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_output_stream_collector.sv
// tb/tb_output_stream_collector.sv - directed self-checking bench for output_stream_collector
module tb_output_stream_collector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        start;
  logic [15:0] expected_words;
  logic        done;
  logic        busy;
  logic        error;
  logic [15:0] accepted;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  output_stream_collector_if sif ();

  output_stream_collector #(
    .DEPTH     (8),
    .CNT_WIDTH (16)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .clear_i          (clear),
    .start_i          (start),
    .expected_words_i (expected_words),
    .strm             (sif),
    .done_o           (done),
    .busy_o           (busy),
    .error_o          (error),
    .accepted_o       (accepted)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lane(input logic [31:0] b);
`ifdef OUTPUT_COLLECTOR_BYTE_SWAP_EN
    return {b[7:0], b[15:8], b[23:16], b[31:24]};
`else
    return b;
`endif
  endfunction

  function automatic logic [63:0] word(input int i);
    return {32'hB000_0000 | 32'(i), 32'hA000_0000 | 32'(i)};
  endfunction

  function automatic logic [31:0] beat_of(input int w, input int half);
    logic [63:0] d;
    d = word(w);
    return lane(half == 0 ? d[31:0] : d[63:32]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pushed;
    int bidx;
    bit got_done;

    rst_n = 1'b0;
    clear = 1'b0;
    start = 1'b0;
    expected_words = '0;
    sif.in_valid = 1'b0;
    sif.in_data = '0;
    sif.out_ready = 1'b1;
    tick();
    tick();
    settle();
    check("rst_in_ready", sif.in_ready, 1);
    check("rst_out_valid", sif.out_valid, 0);
    check("rst_out_data", sif.out_data, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
    check("rst_accepted", accepted, 0);
    rst_n = 1'b1;
    tick();

    // Two-word layer, streamer always ready
    start = 1'b1;
    expected_words = 16'd2;
    tick();
    start = 1'b0;
    sif.in_valid = 1'b1;
    sif.in_data = 64'h0807060504030201;
    settle();
    check("t1_busy", busy, 1);
    check("t1_empty", sif.out_valid, 0);
    tick();
    sif.in_data = 64'h100F0E0D0C0B0A09;
    settle();
    check("t1_valid", sif.out_valid, 1);
    check("t1_beat0", sif.out_data, lane(32'h04030201));
    tick();
    sif.in_valid = 1'b0;
    settle();
    check("t1_beat1", sif.out_data, lane(32'h08070605));
    check("t1_accepted", accepted, 2);
    tick();
    settle();
    check("t1_beat2", sif.out_data, lane(32'h0C0B0A09));
    tick();
    settle();
    check("t1_beat3", sif.out_data, lane(32'h100F0E0D));
    check("t1_done_early", done, 0);
    tick();
    settle();
    check("t1_done", done, 1);
    check("t1_busy_fall", busy, 0);
    check("t1_drained", sif.out_valid, 0);
    check("t1_error", error, 0);
    check("t1_strb", sif.out_strb, 4'hF);
    tick();
    settle();
    check("t1_done_pulse", done, 0);

    // Overflow with the streamer stalled
    start = 1'b1;
    expected_words = 16'd20;
    sif.out_ready = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      sif.in_valid = 1'b1;
      sif.in_data = word(i);
      tick();
    end
    sif.in_valid = 1'b0;
    settle();
    check("t2_accepted", accepted, 8);
    check("t2_error", error, 1);
    check("t2_in_ready", sif.in_ready, 0);
    check("t2_busy", busy, 1);
    sif.out_ready = 1'b1;
    for (int b = 0; b < 16; b++) begin
      settle();
      check($sformatf("t2_beat%0d", b), sif.out_data, beat_of(b / 2, b % 2));
      tick();
    end
    settle();
    check("t2_empty", sif.out_valid, 0);
    check("t2_in_ready_back", sif.in_ready, 1);

    // Clear with three words buffered in RUN
    sif.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sif.in_valid = 1'b1;
      sif.in_data = word(50 + i);
      tick();
    end
    sif.in_valid = 1'b0;
    settle();
    check("t6_buffered", sif.out_valid, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    settle();
    check("t6_valid", sif.out_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_accepted", accepted, 0);
    check("t6_error", error, 0);
    check("t6_done", done, 0);
    tick();
    settle();
    check("t6_done_later", done, 0);

    // Full FIFO, push coincides with beat-1 handshake
    start = 1'b1;
    expected_words = 16'd20;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sif.in_valid = 1'b1;
      sif.in_data = word(i);
      tick();
    end
    sif.in_valid = 1'b0;
    settle();
    check("t3_full", sif.in_ready, 0);
    sif.out_ready = 1'b1;
    tick();
    sif.in_valid = 1'b1;
    sif.in_data = word(8);
    settle();
    check("t3_hi_beat", sif.out_data, beat_of(0, 1));
    tick();
    sif.in_valid = 1'b0;
    sif.out_ready = 1'b0;
    settle();
    check("t3_accepted", accepted, 9);
    check("t3_error", error, 0);
    check("t3_still_full", sif.in_ready, 0);
    check("t3_head", sif.out_data, beat_of(1, 0));
    sif.out_ready = 1'b1;
    for (int b = 0; b < 16; b++) begin
      settle();
      check($sformatf("t3_beat%0d", b), sif.out_data, beat_of(1 + b / 2, b % 2));
      tick();
    end
    settle();
    check("t3_empty", sif.out_valid, 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;

    // Toggling backpressure, ten words
    start = 1'b1;
    expected_words = 16'd10;
    tick();
    start = 1'b0;
    pushed = 0;
    bidx = 0;
    for (int c = 0; c < 400; c++) begin
      sif.in_valid = (c % 4 == 0) && (pushed < 10);
      if (sif.in_valid) begin
        sif.in_data = word(100 + pushed);
        pushed++;
      end
      sif.out_ready = c[0];
      settle();
      if (sif.out_valid && bidx < 20)
        check($sformatf("t4_beat%0d_c%0d", bidx, c), sif.out_data, beat_of(100 + bidx / 2, bidx % 2));
      if (sif.out_valid && sif.out_ready) bidx++;
      tick();
      if (bidx >= 20) break;
    end
    sif.in_valid = 1'b0;
    sif.out_ready = 1'b1;
    check("t4_beat_count", bidx, 20);
    got_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      settle();
      if (done) begin
        got_done = 1'b1;
        break;
      end
      tick();
    end
    check("t4_done", got_done, 1);
    check("t4_accepted", accepted, 10);
    check("t4_error", error, 0);
    tick();

    // Stray word in IDLE, then zero-length layer
    clear = 1'b1;
    tick();
    clear = 1'b0;
    sif.in_valid = 1'b1;
    sif.in_data = word(7);
    tick();
    sif.in_valid = 1'b0;
    settle();
    check("t5_error", error, 1);
    check("t5_accepted", accepted, 0);
    check("t5_no_data", sif.out_valid, 0);
    start = 1'b1;
    expected_words = 16'd0;
    tick();
    start = 1'b0;
    settle();
    check("t5_busy", busy, 1);
    check("t5_done_early", done, 0);
    check("t5_error_cleared", error, 0);
    tick();
    settle();
    check("t5_done", done, 1);
    check("t5_busy_fall", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
